mipi_frame_writer: RTL

Capture controller that sits between the MIPI receiver's RGB888 pixel stream and the SDRAM frame buffer. It waits for frame start and counts pixels and lines against the configured geometry. Pixels are packed to RGB565 and staged in a small internal FIFO, then written out as fixed-length Avalon-MM write bursts into one of two ping-pong frame buffers. It reports completed frames and sticky error conditions, and never toggles buffers on a corrupted frame.

---
 rtl/mipi_frame_writer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mipi_frame_writer.sv
`timescale 1ns/1ps
// mipi_frame_writer: RGB888 stream capture into ping-pong RGB565
// frame buffers via fixed-length Avalon-MM write bursts.
module mipi_frame_writer #(
  parameter int pWIDTH      = 640,
  parameter int pHEIGHT     = 480,
  parameter int pBURST      = 8,
  parameter int pFIFO_DEPTH = 32,
  parameter int pADDR_BITS  = 24
) (
  input  logic                    iCLK,
  input  logic                    iRESETn,
  input  logic [23:0]             iPIX_DATA,
  input  logic                    iPIX_START,
  input  logic                    iPIX_VALID,
  input  logic                    iENABLE,
  input  logic                    iSINGLE,
  input  logic [pADDR_BITS-1:0]   iBASE0,
  input  logic [pADDR_BITS-1:0]   iBASE1,
  input  logic                    iCLR_ERR,
  output logic [pADDR_BITS-1:0]   oAVL_ADDRESS,
  output logic                    oAVL_WRITE,
  output logic [15:0]             oAVL_WRITEDATA,
  output logic [$clog2(pBURST):0] oAVL_BURSTCOUNT,
  input  logic                    iAVL_WAITREQUEST,
  output logic                    oFRAME_DONE,
  output logic                    oFRAME_BUF,
  output logic                    oBUSY,
  output logic                    oOVERFLOW,
  output logic                    oFRAME_ERR
);

  localparam int AW = $clog2(pFIFO_DEPTH);
  localparam int BW = $clog2(pBURST) + 1;
  localparam int XW = $clog2(pWIDTH) + 1;
  localparam int YW = $clog2(pHEIGHT) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_CAP   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]            state, state_nxt;
  logic                  armed, cur_buf;
  logic [XW-1:0]         pix_cnt;
  logic [YW-1:0]         line_cnt;
  logic [pADDR_BITS-1:0] offset, base;
  logic [15:0]           mem [pFIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count, count_nxt;
  logic [BW-1:0]         beat;
  logic [15:0]           pix565;
  logic                  push, pop, full, take, ovf_ev, err_ev;
  logic                  sof_ev, frame_last, last_beat, flush_done;
  logic                  drain_done, start_ok, go, chain, start;
  logic                  unused_pix;

  assign pix565     = {iPIX_DATA[23:19], iPIX_DATA[15:10], iPIX_DATA[7:3]};
  assign unused_pix = ^{iPIX_DATA[18:16], iPIX_DATA[9:8], iPIX_DATA[2:0]};

  assign pop        = oAVL_WRITE && !iAVL_WAITREQUEST;
  assign last_beat  = beat == BW'(pBURST - 1);
  assign full       = count == (AW+1)'(pFIFO_DEPTH) && !pop;
  assign sof_ev     = state == S_WAIT && iPIX_START;
  assign err_ev     = (state == S_CAP || state == S_FLUSH) && iPIX_START;
  assign ovf_ev     = state == S_CAP && iPIX_VALID && !iPIX_START && full;
  assign take       = state == S_CAP && iPIX_VALID && !iPIX_START && !full;
  assign push       = take;
  assign frame_last = take && pix_cnt == XW'(pWIDTH - 1)
                      && line_cnt == YW'(pHEIGHT - 1);
  assign count_nxt  = count + (AW+1)'(push) - (AW+1)'(pop);
  assign flush_done = state == S_FLUSH && !iPIX_START && pop && last_beat
                      && count == (AW+1)'(1);
  assign drain_done = state == S_DRAIN && !oAVL_WRITE;
  assign start_ok   = state != S_DRAIN;
  assign go         = !oAVL_WRITE && start_ok
                      && count >= (AW+1)'(pBURST);
  assign chain      = pop && last_beat && start_ok
                      && count_nxt >= (AW+1)'(pBURST);
  assign start      = go || chain;
  assign base       = cur_buf ? iBASE1 : iBASE0;

  assign oAVL_WRITEDATA  = oAVL_WRITE ? mem[rd_ptr] : 16'h0;
  assign oAVL_BURSTCOUNT = oAVL_WRITE ? BW'(pBURST) : '0;

  // next-state decode for the capture sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (iENABLE && armed) state_nxt = S_WAIT;
      S_WAIT:  if (!iENABLE) state_nxt = S_IDLE;
               else if (iPIX_START) state_nxt = S_CAP;
      S_CAP:   if (err_ev || ovf_ev) state_nxt = S_DRAIN;
               else if (frame_last) state_nxt = S_FLUSH;
      S_FLUSH: if (err_ev) state_nxt = S_DRAIN;
               else if (flush_done)
                 state_nxt = (!iSINGLE && iENABLE) ? S_WAIT : S_IDLE;
      S_DRAIN: if (!oAVL_WRITE)
                 state_nxt = iENABLE ? S_WAIT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // sequencer state, arming, buffer select and status outputs
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state       <= S_IDLE;
      armed       <= 1'b1;
      cur_buf     <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oFRAME_BUF  <= 1'b0;
      oBUSY       <= 1'b0;
    end else begin
      state       <= state_nxt;
      oBUSY       <= state_nxt != S_IDLE;
      oFRAME_DONE <= flush_done;
      if (!iENABLE) armed <= 1'b1;
      else if (flush_done && iSINGLE) armed <= 1'b0;
      if (flush_done) begin
        oFRAME_BUF <= cur_buf;
        cur_buf    <= !cur_buf;
      end
    end
  end

  // sticky error flags; a new event beats a simultaneous clear
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      oOVERFLOW  <= 1'b0;
      oFRAME_ERR <= 1'b0;
    end else begin
      if (ovf_ev) oOVERFLOW <= 1'b1;
      else if (iCLR_ERR) oOVERFLOW <= 1'b0;
      if (err_ev) oFRAME_ERR <= 1'b1;
      else if (iCLR_ERR) oFRAME_ERR <= 1'b0;
    end
  end

  // pixel and line position within the frame
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else if (sof_ev) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else if (take) begin
      if (pix_cnt == XW'(pWIDTH - 1)) begin
        pix_cnt  <= '0;
        line_cnt <= line_cnt + 1'b1;
      end else begin
        pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

  // staging FIFO pointers; drain discards whatever is left
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (drain_done) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  // FIFO storage, packed word written as the pixel is accepted
  always_ff @(posedge iCLK) begin
    if (push) mem[wr_ptr] <= pix565;
  end

  // burst engine: address held per burst, bursts may chain
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      oAVL_WRITE   <= 1'b0;
      oAVL_ADDRESS <= '0;
      beat         <= '0;
      offset       <= '0;
    end else begin
      if (sof_ev) offset <= '0;
      else if (start) offset <= offset + pADDR_BITS'(pBURST);
      if (start) begin
        oAVL_WRITE   <= 1'b1;
        oAVL_ADDRESS <= base + {offset[pADDR_BITS-2:0], 1'b0};
        beat         <= '0;
      end else if (pop) begin
        if (last_beat) begin
          oAVL_WRITE <= 1'b0;
          beat       <= '0;
        end else begin
          beat <= beat + 1'b1;
        end
      end
    end
  end

endmodule
